vrampx_arbiter: RTL and testbench

Arbiter for the single-port pixel-plane VRAM (VRAMpixel, 17-bit address, 8-bit data). The pixel engine has absolute priority, while CPU accesses run only in cycles the engine does not need. CPU writes are buffered in a small FIFO and drained during blanking. CPU reads are serviced one at a time, ordered after all earlier writes. The block sits between the frame synthesizer's pixel engine, the CPU memory-mapped VRAM port and the VRAMpixel memory, all on the pixel clock.

---
 rtl/vrampx_pkg.sv | 10 +
 rtl/vrampx_wfifo.sv | 37 +++
 rtl/vrampx_arbiter.sv | 71 +++++++
 tb/tb_vrampx_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrampx_pkg.sv
// vrampx_pkg: shared VRAMpixel widths and read-FSM state encoding
package vrampx_pkg;
  localparam int VRAM_ADDR_W = 17;
  localparam int VRAM_DATA_W = 8;
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_PEND  = 2'd1,
    R_ISSUE = 2'd2
  } rstate_t;
endpackage

// File: rtl/vrampx_wfifo.sv
// vrampx_wfifo: synchronous write FIFO; push/pop in, head/full/empty/level out
module vrampx_wfifo #(
  parameter int W     = 25,
  parameter int DEPTH = 8
) (
  input  logic                     clkPixel,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign head  = mem[rp];
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clkPixel) begin
    if (push) mem[wp] <= din;
  end
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/vrampx_arbiter.sv
// vrampx_arbiter: VRAMpixel port arbiter; pixel engine first, CPU writes drained from a FIFO and single reads in blanking slots
module vrampx_arbiter
  import vrampx_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clkPixel,
  input  logic                         reset,
  input  logic                         blank,
  input  logic                         gpu_req,
  input  logic [ADDR_W-1:0]            gpu_addr,
  output logic [DATA_W-1:0]            gpu_q,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_ready,
  output logic                         cpu_rvalid,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]            ram_d,
  output logic                         ram_we,
  input  logic [DATA_W-1:0]            ram_q
);
  rstate_t                   rstate;
  logic [ADDR_W-1:0]         rd_addr;
  logic [ADDR_W+DATA_W-1:0]  head;
  logic                      full, empty, cpu_slot, push, drain, issue, rd_acc;
  assign cpu_slot  = blank & ~gpu_req;
  // reads wait for an empty FIFO, which orders them after every earlier write
  assign cpu_ready = (rstate == R_IDLE) && (cpu_we ? !full : empty);
  assign push      = cpu_req & cpu_ready & cpu_we;
  assign rd_acc    = cpu_req & cpu_ready & ~cpu_we;
  assign drain     = cpu_slot & ~empty;
  // a pending read implies an empty FIFO, so issue never collides with drain
  assign issue     = cpu_slot && (rstate == R_PEND);
  assign ram_addr  = drain ? head[ADDR_W+DATA_W-1:DATA_W] : issue ? rd_addr : gpu_addr;
  assign ram_d     = head[DATA_W-1:0];
  assign ram_we    = drain;
  assign gpu_q     = ram_q;
  vrampx_wfifo #(.W(ADDR_W+DATA_W), .DEPTH(FIFO_DEPTH)) u_wfifo (
    .clkPixel (clkPixel),
    .reset    (reset),
    .push     (push),
    .pop      (drain),
    .din      ({cpu_addr, cpu_wdata}),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      rstate     <= R_IDLE;
      rd_addr    <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_rvalid <= rstate == R_ISSUE;
      if (rstate == R_ISSUE) cpu_rdata <= ram_q;
      if (rd_acc) begin
        rstate  <= R_PEND;
        rd_addr <= cpu_addr;
      end else if (issue) rstate <= R_ISSUE;
      else if (rstate == R_ISSUE) rstate <= R_IDLE;
    end
  end
endmodule

// File: tb/tb_vrampx_arbiter.sv
// tb_vrampx_arbiter: directed scoreboard bench for vrampx_arbiter with a synchronous VRAM model
module tb_vrampx_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;
  logic          clkPixel = 0, reset = 1, blank = 0, gpu_req = 0, cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] gpu_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] gpu_q, cpu_rdata, ram_d;
  logic [DW-1:0] ram_q = '0;
  logic [AW-1:0] ram_addr;
  logic          cpu_ready, cpu_rvalid, ram_we;
  logic [3:0]    fifo_level;
  int checks = 0, errors = 0, cyc = 0, rv_count = 0, rv_edge = 0, acc_edge = 0, slot_edge = 0, base = 0;
  logic [AW+DW-1:0] exp_wq [$];
  logic [DW-1:0]    exp_rq [$];
  logic [DW-1:0]    shadow [int];
  logic [DW-1:0]    mem [0:(1<<AW)-1];
  bit               wr [0:(1<<AW)-1];
  always #5 clkPixel = ~clkPixel;
  vrampx_arbiter dut (
    .clkPixel   (clkPixel),
    .reset      (reset),
    .blank      (blank),
    .gpu_req    (gpu_req),
    .gpu_addr   (gpu_addr),
    .gpu_q      (gpu_q),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .fifo_level (fifo_level),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .ram_q      (ram_q)
  );
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[16:9] ^ 8'h5A;
  endfunction
  function automatic logic [DW-1:0] model_val(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
  endfunction
  always @(posedge clkPixel) begin
    ram_q <= wr[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    if (ram_we) begin
      mem[ram_addr] <= ram_d;
      wr[ram_addr]  <= 1'b1;
    end
  end
  always @(posedge clkPixel) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  logic [AW+DW-1:0] we_exp;
  always @(negedge clkPixel) begin
    if (!(blank && !gpu_req)) begin
      check("noslot_we", ram_we, 0);
      check("noslot_addr", ram_addr, gpu_addr);
    end
    check("gpu_q", gpu_q, ram_q);
    if (ram_we) begin
      if (exp_wq.size() == 0) check("spurious_we", ram_we, 0);
      else begin
        we_exp = exp_wq.pop_front();
        check("drain_order", {ram_addr, ram_d}, we_exp);
        shadow[int'(we_exp[AW+DW-1:DW])] = we_exp[DW-1:0];
      end
    end
    if (cpu_rvalid) begin
      rv_count++;
      rv_edge = cyc;
      if (exp_rq.size() == 0) check("spurious_rv", cpu_rvalid, 0);
      else check("rdata", cpu_rdata, exp_rq.pop_front());
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clkPixel);
    #1;
  endtask
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clkPixel);
      ok = cpu_ready;
    end
    check("wr_accept", ok, 1);
    @(posedge clkPixel);
    if (ok) exp_wq.push_back({a, d});
    #1;
    cpu_req = 0;
  endtask
  task automatic cpu_read(input logic [AW-1:0] a);
    bit ok = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = a;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clkPixel);
      ok = cpu_ready;
    end
    check("rd_accept", ok, 1);
    @(posedge clkPixel);
    if (ok) exp_rq.push_back(model_val(a));
    #1;
    acc_edge = cyc;
    cpu_req = 0;
  endtask
  task automatic wait_rv(input int b);
    for (int i = 0; i < 50 && rv_count == b; i++) tick();
    check("rv_arrive", rv_count, b + 1);
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 40 && fifo_level != 0; i++) tick();
    check("fifo_empty", fifo_level, 0);
    check("wq_done", exp_wq.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1; blank = 0; gpu_req = 1; gpu_addr = 17'h00100; cpu_we = 1;
    tick(2);
    @(negedge clkPixel);
    check("rst_ready", cpu_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_rvalid", cpu_rvalid, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_we", ram_we, 0);
    tick();
    reset = 0;
    @(negedge clkPixel);
    check("gpu_addr_out", ram_addr, 17'h00100);
    check("gpu_we_out", ram_we, 0);
    check("idle_ready", cpu_ready, 1);
    check("idle_level", fifo_level, 0);
    tick();
    gpu_req = 0;
    for (int i = 0; i < 8; i++) cpu_write(17'(i), 8'hA0 + 8'(i));
    @(negedge clkPixel);
    check("full_ready", cpu_ready, 0);
    check("full_level", fifo_level, 8);
    tick();
    blank = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkPixel);
      check("drain_we", ram_we, 1);
      check("drain_level", fifo_level, 8 - i);
    end
    @(negedge clkPixel);
    check("drained_we", ram_we, 0);
    check("drained_level", fifo_level, 0);
    check("drained_wq", exp_wq.size(), 0);
    tick();
    blank = 0;
    for (int i = 0; i < 6; i++) cpu_write(17'h00100 + 17'(i), 8'h30 + 8'(i));
    blank = 1;
    tick(2);
    gpu_req = 1; gpu_addr = 17'h0ABCD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkPixel);
      check("gpu_pri_we", ram_we, 0);
      check("gpu_pri_addr", ram_addr, 17'h0ABCD);
      check("gpu_pri_level", fifo_level, 4);
      tick();
    end
    gpu_req = 0;
    wait_empty();
    cpu_write(17'h1FFFF, 8'h5C);
    cpu_req = 1; cpu_we = 0; cpu_addr = 17'h1FFFF;
    @(negedge clkPixel);
    check("rd_blocked", cpu_ready, 0);
    base = rv_count;
    cpu_read(17'h1FFFF);
    check("rd_wait_ready", cpu_ready, 0);
    wait_rv(base);
    check("rd_latency", rv_edge + 1 - acc_edge, 3);
    check("rd_value", cpu_rdata, 8'h5C);
    tick(5);
    check("rv_once", rv_count, base + 1);
    blank = 0;
    base = rv_count;
    cpu_read(17'h00042);
    for (int i = 0; i < 20; i++) begin
      gpu_req = 1'(i);
      gpu_addr = 17'h00800 + 17'(i);
      tick();
    end
    check("no_issue", rv_count, base);
    gpu_req = 0;
    blank = 1;
    slot_edge = cyc;
    @(negedge clkPixel);
    check("issue_addr", ram_addr, 17'h00042);
    check("issue_we", ram_we, 0);
    tick();
    gpu_req = 1; gpu_addr = 17'h00777;
    wait_rv(base);
    check("rv_after_slot", rv_edge - slot_edge, 2);
    check("rd_held_value", cpu_rdata, init_val(17'h00042));
    gpu_req = 0;
    blank = 0;
    for (int i = 0; i < 3; i++) cpu_write(17'h00200 + 17'(i), 8'h70 + 8'(i));
    cpu_req = 1; cpu_we = 1; cpu_addr = 17'h00203; cpu_wdata = 8'h73;
    blank = 1;
    @(negedge clkPixel);
    check("pp_ready", cpu_ready, 1);
    check("pp_we", ram_we, 1);
    check("pp_level_before", fifo_level, 3);
    @(posedge clkPixel);
    exp_wq.push_back({17'h00203, 8'h73});
    #1;
    cpu_req = 0;
    blank = 0;
    @(negedge clkPixel);
    check("pp_level_after", fifo_level, 3);
    tick();
    blank = 1;
    wait_empty();
    base = rv_count;
    cpu_read(17'h1FFFF);
    wait_rv(base);
    blank = 0;
    for (int i = 0; i < 5; i++) cpu_write(17'h00300 + 17'(i), 8'hC0 + 8'(i));
    @(negedge clkPixel);
    check("pre_rst_level", fifo_level, 5);
    tick();
    reset = 1;
    exp_wq.delete();
    @(negedge clkPixel);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_we", ram_we, 0);
    tick();
    reset = 0;
    blank = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 17'h00360; cpu_wdata = 8'h99;
    @(negedge clkPixel);
    check("post_rst_ready", cpu_ready, 1);
    @(posedge clkPixel);
    exp_wq.push_back({17'h00360, 8'h99});
    #1;
    cpu_req = 0;
    tick(4);
    check("post_rst_wq", exp_wq.size(), 0);
    blank = 0;
    base = rv_count;
    cpu_read(17'h00055);
    tick(3);
    reset = 1;
    exp_rq.delete();
    @(negedge clkPixel);
    check("rst_pend_rvalid", cpu_rvalid, 0);
    check("rst_pend_rdata", cpu_rdata, 0);
    check("rst_pend_ready", cpu_ready, 1);
    tick();
    reset = 0;
    blank = 1;
    tick(8);
    check("no_rv_after_rst", rv_count, base);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
